// File: rtl/ram_writer.sv
// rtl/ram_writer.sv - single-port-write RAM with host writes and whole-memory fill engine
//
// Purpose:
//   Holds a 2**ADDR_W x DATA_W memory that can be written either by a host
//   (valid/ready handshake) or by an internal fill engine that writes one
//   value to every address, one address per cycle. A registered read port
//   returns mem[rd_addr] one cycle later, read-before-write.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   reset      in   asynchronous active-high reset
//   wr_valid   in   host write request
//   wr_ready   out  host write can be accepted (IDLE only)
//   wr_addr    in   host write address
//   wr_data    in   host write data
//   fill_start in   start a fill of the whole memory (IDLE only)
//   fill_data  in   fill value, captured together with fill_start
//   busy       out  fill in progress
//   done       out  one-cycle pulse after the last fill write
//   rd_addr    in   read address
//   rd_data    out  registered read data
//   wr_count   out  accepted host writes, saturating (only with RAM_WRITER_COUNT_EN)
//
// Configuration:
//   RAM_WRITER_COUNT_EN - when defined, adds the 16-bit wr_count output.

module ram_writer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
`ifdef RAM_WRITER_COUNT_EN
    ,
    output logic [15:0]       wr_count
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  cnt_q;
    logic [DATA_W-1:0]  fill_val_q;
    logic               wr_ready_q;
    logic               busy_q;
    logic               done_q;
    logic [DATA_W-1:0]  rd_data_q;

    logic [DATA_W-1:0]  mem [DEPTH];

    // Memory write port selection
    logic               host_acc;
    logic               fill_wr;
    logic               mem_we_d;
    logic [ADDR_W-1:0]  mem_waddr_d;
    logic [DATA_W-1:0]  mem_wdata_d;

    always_comb begin
        // fill_start wins over a simultaneous host write; writes are also
        // suppressed while reset is held so an aborted fill stops cleanly.
        host_acc    = !reset && wr_ready_q && wr_valid && !fill_start;
        fill_wr     = !reset && busy_q;
        mem_we_d    = host_acc || fill_wr;
        mem_waddr_d = wr_addr;
        mem_wdata_d = wr_data;
        if (fill_wr) begin
            mem_waddr_d = cnt_q;
            mem_wdata_d = fill_val_q;
        end
    end

    // Control FSM. Status outputs are registered alongside the state so
    // they never depend combinationally on inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            fill_val_q <= '0;
            wr_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fill_start) begin
                        state_q    <= ST_FILL;
                        fill_val_q <= fill_data;
                        cnt_q      <= '0;
                        wr_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_FILL: begin
                    // Counter wraps back to 0 on the final write.
                    cnt_q <= cnt_q + ADDR_W'(1);
                    if (cnt_q == {ADDR_W{1'b1}}) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q    <= ST_IDLE;
                    done_q     <= 1'b0;
                    wr_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    wr_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    // Memory array is deliberately not reset: contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem[mem_waddr_d] <= mem_wdata_d;
        end
    end

    // Registered read: samples the array before this edge's write lands,
    // which gives read-before-write on address collisions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

`ifdef RAM_WRITER_COUNT_EN
    logic [15:0] wr_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count_q <= '0;
        end else if (host_acc && (wr_count_q != 16'hFFFF)) begin
            wr_count_q <= wr_count_q + 16'd1;
        end
    end

    assign wr_count = wr_count_q;
`endif

    assign wr_ready = wr_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_ram_writer.sv
// tb/tb_ram_writer.sv - self-checking bench for ram_writer against an array reference model

module tb_ram_writer;

    logic       clk;
    logic       reset;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_addr;
    logic [3:0] wr_data;
    logic       fill_start;
    logic [3:0] fill_data;
    logic       busy;
    logic       done;
    logic [7:0] rd_addr;
    logic [3:0] rd_data;
`ifdef RAM_WRITER_COUNT_EN
    logic [15:0] wr_count;
`endif

    int n_pass;
    int n_total;

    // Reference memory: expected contents of every address
    logic [3:0] ref_mem [256];
    int         ref_count;

    ram_writer #(.ADDR_W(8), .DATA_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .fill_start (fill_start),
        .fill_data  (fill_data),
        .busy       (busy),
        .done       (done),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
`ifdef RAM_WRITER_COUNT_EN
        ,
        .wr_count   (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [7:0] a, output logic [3:0] d);
        wr_valid = 1'b0;
        fill_start = 1'b0;
        rd_addr = a;
        step();
        d = rd_data;
    endtask

    task automatic host_write(input logic [7:0] a, input logic [3:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
        ref_mem[a] = d;
        ref_count++;
    endtask

    // Runs a complete fill and returns the number of cycles busy was seen high
    task automatic run_fill(input logic [3:0] v, output int busy_cycles, output bit got_done);
        fill_start = 1'b1;
        fill_data  = v;
        step();
        fill_start = 1'b0;
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 400) begin
            busy_cycles++;
            step();
        end
        got_done = (done === 1'b1);
        step();
        for (int i = 0; i < 256; i++) ref_mem[i] = v;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_total++;
        if (wr_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rd_data !== 4'h0)
            $display("FAIL reset_state: ready=%b busy=%b done=%b rd=%h, required 1 0 0 0",
                     wr_ready, busy, done, rd_data);
        else n_pass++;
        step();
        step();
        reset = 1'b0;
        step();
        n_total++;
        if (wr_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_release: ready=%b busy=%b, required 1 0", wr_ready, busy);
        else n_pass++;
    endtask

    task automatic test_host_write();
        logic [3:0] d;
        host_write(8'h3C, 4'hA);
        do_read(8'h3C, d);
        n_total++;
        if (d !== 4'hA) $display("FAIL host_write: rd_data=%h required %h", d, 4'hA);
        else n_pass++;
        // Memory must survive a reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        do_read(8'h3C, d);
        n_total++;
        if (d !== 4'hA) $display("FAIL mem_kept_over_reset: rd_data=%h required %h", d, 4'hA);
        else n_pass++;
    endtask

    task automatic test_fill();
        int bad;
        int cyc;
        logic [3:0] d;
        logic [7:0] addrs [3];
        addrs[0] = 8'h00; addrs[1] = 8'h80; addrs[2] = 8'hFF;
        fill_start = 1'b1;
        fill_data  = 4'h5;
        step();
        fill_start = 1'b0;
        fill_data  = 4'($urandom);
        cyc = 0;
        bad = 0;
        while (busy === 1'b1 && cyc < 400) begin
            if (wr_ready !== 1'b0 || done !== 1'b0) bad++;
            cyc++;
            step();
        end
        n_total++;
        if (cyc != 256) $display("FAIL fill_busy_cycles: saw %0d required 256", cyc);
        else n_pass++;
        n_total++;
        if (bad != 0) $display("FAIL fill_flags: %0d cycles with ready/done high, required 0", bad);
        else n_pass++;
        n_total++;
        if (done !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b0)
            $display("FAIL fill_done: done=%b busy=%b ready=%b required 1 0 0", done, busy, wr_ready);
        else n_pass++;
        step();
        n_total++;
        if (done !== 1'b0 || wr_ready !== 1'b1)
            $display("FAIL fill_back_idle: done=%b ready=%b required 0 1", done, wr_ready);
        else n_pass++;
        for (int i = 0; i < 256; i++) ref_mem[i] = 4'h5;
        for (int i = 0; i < 3; i++) begin
            do_read(addrs[i], d);
            n_total++;
            if (d !== 4'h5) $display("FAIL fill_read_%h: rd_data=%h required 5", addrs[i], d);
            else n_pass++;
        end
    endtask

    task automatic test_random_traffic();
        logic [7:0] ra;
        logic [3:0] exp;
        int bad;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            ra       = 8'($urandom);
            wr_valid = ($urandom_range(0, 1) == 1);
            wr_addr  = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            wr_data  = 4'($urandom);
            rd_addr  = ra;
            exp      = ref_mem[ra];
            if (wr_ready !== 1'b1) bad++;
            if (wr_valid) begin
                ref_mem[wr_addr] = wr_data;
                ref_count++;
            end
            step();
            n_total++;
            if (rd_data !== exp) begin
                $display("FAIL random_read[%0d]: addr=%h rd_data=%h required %h", i, ra, rd_data, exp);
            end else n_pass++;
        end
        wr_valid = 1'b0;
        n_total++;
        if (bad != 0) $display("FAIL random_ready: %0d cycles not ready, required 0", bad);
        else n_pass++;
    endtask

    task automatic test_priority();
        int cyc;
        logic [3:0] d;
        fill_start = 1'b1;
        fill_data  = 4'h2;
        wr_valid   = 1'b1;
        wr_addr    = 8'h10;
        wr_data    = 4'hF;
        step();
        fill_start = 1'b0;
        wr_valid   = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL priority_busy: busy=%b required 1", busy);
        else n_pass++;
        cyc = 0;
        while (busy === 1'b1 && cyc < 400) begin cyc++; step(); end
        step();
        for (int i = 0; i < 256; i++) ref_mem[i] = 4'h2;
        do_read(8'h10, d);
        n_total++;
        if (d !== 4'h2) $display("FAIL priority_mem: rd_data=%h required 2", d);
        else n_pass++;
    endtask

    task automatic test_ignore();
        logic [3:0] fv;
        logic [3:0] d;
        int cyc;
        int bad;
        fv = 4'($urandom_range(0, 8));
        fill_start = 1'b1;
        fill_data  = fv;
        step();
        // Host write and a second fill request during FILL must be dropped
        fill_data  = ~fv;
        wr_valid   = 1'b1;
        wr_addr    = 8'h20;
        wr_data    = 4'h9;
        bad = 0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 400) begin
            if (wr_ready !== 1'b0) bad++;
            if (cyc == 200) begin wr_valid = 1'b0; fill_start = 1'b0; end
            cyc++;
            step();
        end
        n_total++;
        if (bad != 0 || cyc != 256)
            $display("FAIL ignore_ready: notready_violations=%0d cycles=%0d required 0 256", bad, cyc);
        else n_pass++;
        step();
        step();
        n_total++;
        if (busy !== 1'b0 || wr_ready !== 1'b1)
            $display("FAIL ignore_no_queue: busy=%b ready=%b required 0 1", busy, wr_ready);
        else n_pass++;
        for (int i = 0; i < 256; i++) ref_mem[i] = fv;
        do_read(8'h20, d);
        n_total++;
        if (d !== fv) $display("FAIL ignore_mem: rd_data=%h required %h", d, fv);
        else n_pass++;
    endtask

    task automatic test_read_before_write();
        host_write(8'h01, 4'h3);
        rd_addr  = 8'h01;
        wr_valid = 1'b1;
        wr_addr  = 8'h01;
        wr_data  = 4'hC;
        step();
        wr_valid = 1'b0;
        ref_mem[8'h01] = 4'hC;
        ref_count++;
        n_total++;
        if (rd_data !== 4'h3) $display("FAIL rbw_old: rd_data=%h required 3", rd_data);
        else n_pass++;
        step();
        n_total++;
        if (rd_data !== 4'hC) $display("FAIL rbw_new: rd_data=%h required c", rd_data);
        else n_pass++;
    endtask

    task automatic test_reset_midfill();
        int bc;
        bit gd;
        bit done_seen;
        logic [3:0] d;
        logic [7:0] a;
        run_fill(4'h0, bc, gd);
        fill_start = 1'b1;
        fill_data  = 4'h7;
        step();
        fill_start = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            done_seen |= (done === 1'b1);
            step();
        end
        reset = 1'b1;
        #1;
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0 || wr_ready !== 1'b1 || rd_data !== 4'h0)
            $display("FAIL midfill_reset: busy=%b done=%b ready=%b rd=%h required 0 0 1 0",
                     busy, done, wr_ready, rd_data);
        else n_pass++;
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) ref_mem[i] = 4'h7;
        for (int i = 0; i < 11; i++) begin
            do_read(8'(i), d);
            done_seen |= (done === 1'b1);
            n_total++;
            if (d !== ref_mem[i]) $display("FAIL midfill_read_%0d: rd_data=%h required %h", i, d, ref_mem[i]);
            else n_pass++;
        end
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom_range(11, 255));
            do_read(a, d);
            done_seen |= (done === 1'b1);
            n_total++;
            if (d !== ref_mem[a]) $display("FAIL midfill_tail_%h: rd_data=%h required %h", a, d, ref_mem[a]);
            else n_pass++;
        end
        n_total++;
        if (done_seen) $display("FAIL midfill_done: done pulsed=1 required 0");
        else n_pass++;
    endtask

`ifdef RAM_WRITER_COUNT_EN
    task automatic test_count();
        int bc;
        bit gd;
        reset = 1'b1;
        #1;
        n_total++;
        if (wr_count !== 16'd0) $display("FAIL count_reset: wr_count=%0d required 0", wr_count);
        else n_pass++;
        step();
        reset = 1'b0;
        ref_count = 0;
        for (int i = 0; i < 7; i++) host_write(8'($urandom), 4'($urandom));
        run_fill(4'h1, bc, gd);
        host_write(8'h44, 4'h4);
        n_total++;
        if (wr_count !== 16'(ref_count))
            $display("FAIL count_value: wr_count=%0d required %0d", wr_count, ref_count);
        else n_pass++;
    endtask
`endif

    initial begin
        n_pass = 0;
        n_total = 0;
        ref_count = 0;
        reset = 1'b0;
        wr_valid = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        fill_start = 1'b0;
        fill_data = '0;
        rd_addr = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 4'h0;
        test_reset();
        test_host_write();
        test_fill();
        test_random_traffic();
        test_priority();
        test_ignore();
        test_read_before_write();
        test_reset_midfill();
`ifdef RAM_WRITER_COUNT_EN
        test_count();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
